// File: rtl/parity_pkg.sv
// Shared definitions for the burst parity generator.
//   state_t    : controller states (IDLE, ACCUM, DONE)
//   lane_xor() : XOR reduction of one lane slice of a data word
//   lanes_ok() : configuration check, DATA_W must split evenly into LANES
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANES  = 4;
  // Widest word lane_xor() can slice; wider DATA_W is rejected by lanes_ok().
  localparam int unsigned MAX_DATA_W = 256;

  localparam bit DEF_CFG_OK = (DEF_DATA_W % DEF_LANES) == 0;

  function automatic bit lanes_ok(input int unsigned dw, input int unsigned lanes);
    return (lanes != 0) && ((dw % lanes) == 0) && (dw <= MAX_DATA_W);
  endfunction

  // XOR of bits [(lane+1)*lane_w-1 : lane*lane_w]; data is zero-extended to MAX_DATA_W.
  function automatic logic lane_xor(input logic [MAX_DATA_W-1:0] data,
                                    input int unsigned lane,
                                    input int unsigned lane_w);
    logic r;
    r = 1'b0;
    for (int unsigned b = 0; b < MAX_DATA_W; b++) begin
      if (b >= lane * lane_w && b < (lane + 1) * lane_w) r ^= data[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/parity_lane_reduce.sv
// Combinational parity reduction of one data word.
//   data : input word, DATA_W bits
//   par  : par[i] = XOR of lane i (i < LANES), par[LANES] = XOR of the whole word
module parity_lane_reduce
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = DEF_LANES
) (
  input  logic [DATA_W-1:0] data,
  output logic [LANES:0]    par
);

  localparam int unsigned LANE_W = DATA_W / LANES;

  logic [MAX_DATA_W-1:0] data_ext;

  assign data_ext = MAX_DATA_W'(data);

  always_comb begin
    par = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      par[i] = lane_xor(data_ext, i, LANE_W);
    end
    par[LANES] = ^data;
  end

endmodule

// File: rtl/parity_stream_gen.sv
// Burst parity generator: accumulates whole-word and per-lane parity over a
// burst of 1..MAX_WORDS words received on a valid/ready stream, then holds
// the result until the consumer acknowledges it.
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   start, len, odd_mode: burst request, sampled in IDLE only
//   abort               : synchronous cancel back to IDLE (highest priority)
//   in_data/in_valid/in_ready : input word stream
//   parity_bit, lane_parity, word_count : result, held in IDLE until next start
//   out_valid/out_ready : result handshake
//   busy                : high in ACCUM or DONE
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned LANES     = DEF_LANES,
  parameter  int unsigned MAX_WORDS = 16,
  localparam int unsigned LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              odd_mode,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              parity_bit,
  output logic [LANES-1:0]  lane_parity,
  output logic [LEN_W-1:0]  word_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  if (!DEF_CFG_OK || !lanes_ok(DATA_W, LANES)) begin : g_cfg_err
    $error("parity_stream_gen: DATA_W must be a non-zero multiple of LANES");
  end

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] count_inc;
  logic             odd_q;
  logic             acc;
  logic [LANES-1:0] lane_acc;
  logic [LANES:0]   word_par;
  logic             accept;
  logic             last_word;

  parity_lane_reduce #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_reduce (
    .data (in_data),
    .par  (word_par)
  );

  assign len_eff   = (len > MAX_LEN) ? MAX_LEN : len;
  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign count_inc = word_count + LEN_W'(1);
  assign last_word = accept && (count_inc == len_q);

  // Result is the raw accumulators with the latched polarity applied; since
  // nothing but start/abort touches them outside ACCUM, the result persists in IDLE.
  assign parity_bit  = acc ^ odd_q;
  assign lane_parity = lane_acc ^ {LANES{odd_q}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      odd_q      <= 1'b0;
      acc        <= 1'b0;
      lane_acc   <= '0;
      word_count <= '0;
    end else if (abort) begin
      odd_q      <= 1'b0;
      acc        <= 1'b0;
      lane_acc   <= '0;
      word_count <= '0;
    end else if (state == IDLE && start) begin
      len_q      <= len_eff;
      odd_q      <= odd_mode;
      acc        <= 1'b0;
      lane_acc   <= '0;
      word_count <= '0;
    end else if (accept) begin
      acc        <= acc ^ word_par[LANES];
      lane_acc   <= lane_acc ^ word_par[LANES-1:0];
      word_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_parity_stream_gen.sv
// Directed bench for parity_stream_gen with a result scoreboard.
module tb_parity_stream_gen;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = DATA_W / LANES;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned LEN_W     = $clog2(MAX_WORDS + 1);

  typedef struct packed {
    logic             pb;
    logic [LANES-1:0] lp;
    logic [LEN_W-1:0] wc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              odd_mode;
  logic              abort;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              parity_bit;
  logic [LANES-1:0]  lane_parity;
  logic [LEN_W-1:0]  word_count;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  logic             m_acc;
  logic [LANES-1:0] m_lanes;
  logic [LEN_W-1:0] m_cnt;

  parity_stream_gen #(
    .DATA_W    (DATA_W),
    .LANES     (LANES),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .odd_mode    (odd_mode),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .parity_bit  (parity_bit),
    .lane_parity (lane_parity),
    .word_count  (word_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed still running, required finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES-1:0] lanes_of(input logic [DATA_W-1:0] d);
    logic [LANES-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[i] = ^d[i*LANE_W +: LANE_W];
    return r;
  endfunction

  task automatic model_clear();
    m_acc   = 1'b0;
    m_lanes = '0;
    m_cnt   = '0;
  endtask

  task automatic push_expected(input logic odd);
    sb.push_back('{pb: m_acc ^ odd, lp: m_lanes ^ {LANES{odd}}, wc: m_cnt});
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l, input logic odd);
    start    = 1'b1;
    len      = l;
    odd_mode = odd;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send_word(input string tag, input logic [DATA_W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    m_acc   ^= ^d;
    m_lanes ^= lanes_of(d);
    m_cnt++;
  endtask

  task automatic wait_result(input string tag, output exp_t e);
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    check({tag, "_out_valid"}, 32'(out_valid), 32'(1));
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_entry"}, 32'(0), 32'(1));
      e = '0;
    end else begin
      e = sb.pop_front();
      check({tag, "_parity_bit"},  32'(parity_bit),  32'(e.pb));
      check({tag, "_lane_parity"}, 32'(lane_parity), 32'(e.lp));
      check({tag, "_word_count"},  32'(word_count),  32'(e.wc));
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ack_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_ack_busy"},      32'(busy),      32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},    32'(in_ready),    32'(0));
    check({tag, "_out_valid"},   32'(out_valid),   32'(0));
    check({tag, "_busy"},        32'(busy),        32'(0));
    check({tag, "_parity_bit"},  32'(parity_bit),  32'(0));
    check({tag, "_lane_parity"}, 32'(lane_parity), 32'(0));
    check({tag, "_word_count"},  32'(word_count),  32'(0));
  endtask

  initial begin
    exp_t e;
    logic seen;

    rst       = 1'b0;
    start     = 1'b0;
    len       = '0;
    odd_mode  = 1'b0;
    abort     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();

    // Reset state
    tick();
    check_reset_values("reset");
    #3 rst = 1'b1;
    tick();

    // Single word, even mode; result one cycle after accept
    do_start(LEN_W'(1), 1'b0);
    send_word("t1", 32'h0000_0007);
    check("t1_latency", 32'(out_valid), 32'(1));
    push_expected(1'b0);
    wait_result("t1", e);
    ack("t1");

    // 3-word burst, odd mode, with input gaps and an ignored start mid-burst
    do_start(LEN_W'(3), 1'b1);
    send_word("t2w0", 32'hFF00_00FF);
    tick();
    start    = 1'b1;
    len      = LEN_W'(1);
    odd_mode = 1'b0;
    tick();
    start = 1'b0;
    send_word("t2w1", 32'h0100_0000);
    tick();
    send_word("t2w2", 32'h0000_0001);
    check("t2_in_ready_low", 32'(in_ready), 32'(0));
    push_expected(1'b1);
    wait_result("t2", e);

    // Backpressure: result held stable while out_ready is low
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid",   32'(out_valid),   32'(1));
      check("bp_parity_bit",  32'(parity_bit),  32'(e.pb));
      check("bp_lane_parity", 32'(lane_parity), 32'(e.lp));
      check("bp_word_count",  32'(word_count),  32'(e.wc));
    end
    ack("bp");
    check("bp_hold_parity_idle", 32'(parity_bit),  32'(e.pb));
    check("bp_hold_lanes_idle",  32'(lane_parity), 32'(e.lp));

    // len=0, odd mode: straight to DONE
    do_start(LEN_W'(0), 1'b1);
    check("t3_done_latency", 32'(out_valid), 32'(1));
    push_expected(1'b1);
    wait_result("t3", e);
    ack("t3");

    // Over-length request clamps to MAX_WORDS
    do_start(LEN_W'(20), 1'b0);
    for (int i = 0; i < int'(MAX_WORDS); i++) send_word("clamp", DATA_W'($urandom));
    check("clamp_in_ready_low", 32'(in_ready), 32'(0));
    push_expected(1'b0);
    wait_result("clamp", e);
    ack("clamp");

    // len=1 even mode equals plain word parity
    for (int i = 0; i < 3; i++) begin
      do_start(LEN_W'(1), 1'b0);
      send_word("equiv", DATA_W'($urandom));
      push_expected(1'b0);
      wait_result("equiv", e);
      ack("equiv");
    end

    // Abort after 2 of 4 words, with start and a data word in the same cycle
    do_start(LEN_W'(4), 1'b0);
    send_word("ab_w0", 32'h1234_5678);
    send_word("ab_w1", 32'h0F0F_0F01);
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    abort    = 1'b1;
    start    = 1'b1;
    len      = LEN_W'(1);
    tick();
    abort    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy",      32'(busy),      32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready",  32'(in_ready),  32'(0));
    seen = out_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("abort_no_result", 32'(seen), 32'(0));
    do_start(LEN_W'(1), 1'b0);
    send_word("after_abort", 32'h0000_0000);
    push_expected(1'b0);
    wait_result("after_abort", e);
    ack("after_abort");

    // Asynchronous reset mid-burst; start ignored while held in reset
    do_start(LEN_W'(4), 1'b1);
    send_word("rst_w0", 32'h0000_0003);
    in_data  = 32'h0000_0001;
    in_valid = 1'b1;
    #3 rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    start = 1'b1;
    len   = LEN_W'(2);
    tick();
    tick();
    check("rst_start_busy",     32'(busy),     32'(0));
    check("rst_start_in_ready", 32'(in_ready), 32'(0));
    start    = 1'b0;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    tick();
    check("rst_release_busy", 32'(busy), 32'(0));
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
